// File: rtl/spu_pipe_ctrl_pkg.sv
// Shared encodings for the SPU pipeline stall/flush sequencer.
// Stage registers import this package so they decode stall bits and
// controller states the same way the controller produces them.
// Stall vectors are indexed [0:5]: bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/FF,
// 4=FF/WB, 5=WB. Literals are written left-to-right from bit0.
package spu_pipe_ctrl_pkg;

    localparam int STALL_BUS6 = 6;

    // Stage bit indices into the stall vector.
    localparam int STG_PC    = 0;
    localparam int STG_IF_ID = 1;
    localparam int STG_ID_EX = 2;
    localparam int STG_EX_FF = 3;
    localparam int STG_FF_WB = 4;
    localparam int STG_WB    = 5;

    // Each mask freezes the requesting stage and everything upstream of it.
    localparam logic [0:STALL_BUS6-1] STALL_NONE = 6'b000000;
    localparam logic [0:STALL_BUS6-1] STALL_IF   = 6'b110000;
    localparam logic [0:STALL_BUS6-1] STALL_ID   = 6'b111000;
    localparam logic [0:STALL_BUS6-1] STALL_EX   = 6'b111100;
    localparam logic [0:STALL_BUS6-1] STALL_FF   = 6'b111110;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } pipe_state_e;

    // Highest-numbered requester wins; its mask covers all lower ones.
    function automatic logic [0:STALL_BUS6-1] req_mask(
        input logic if_req,
        input logic id_req,
        input logic ex_req,
        input logic ff_req
    );
        if (ff_req)      return STALL_FF;
        else if (ex_req) return STALL_EX;
        else if (id_req) return STALL_ID;
        else if (if_req) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/spu_pipe_ctrl_if.sv
// Signal bundle between the pipeline stages and the stall/flush sequencer.
// master: the pipeline side (drives stall requests, multi-cycle start,
//         branch resolution; consumes stall/flush/redirect/status).
// slave : the sequencer itself.
// There is no valid/ready handshake here: every signal is sampled on every
// rising clock edge, and pulses (ex_mc_start, ff_branch_flag, pc_redirect,
// mc_done, mc_abort) are exactly one cycle wide per event.
interface spu_pipe_ctrl_if;
    import spu_pipe_ctrl_pkg::*;

    logic                    if_stall_req;
    logic                    id_stall_req;
    logic                    ex_stall_req;
    logic                    ff_stall_req;
    logic                    ex_mc_start;
    logic [0:3]              ex_mc_lat;
    logic                    ff_branch_flag;
    logic [0:31]             ff_branch_target_addr;

    logic [0:STALL_BUS6-1]   stall;
    logic                    flush;
    logic                    pc_redirect;
    logic [0:31]             new_pc;
    logic                    mc_done;
    logic                    mc_abort;
    logic                    hang_err;
    pipe_state_e             dbg_state;

    modport master (
        output if_stall_req, id_stall_req, ex_stall_req, ff_stall_req,
        output ex_mc_start, ex_mc_lat, ff_branch_flag, ff_branch_target_addr,
        input  stall, flush, pc_redirect, new_pc, mc_done, mc_abort, hang_err,
        input  dbg_state
    );

    modport slave (
        input  if_stall_req, id_stall_req, ex_stall_req, ff_stall_req,
        input  ex_mc_start, ex_mc_lat, ff_branch_flag, ff_branch_target_addr,
        output stall, flush, pc_redirect, new_pc, mc_done, mc_abort, hang_err,
        output dbg_state
    );

endinterface

// File: rtl/spu_stall_watchdog.sv
// Stall watchdog: counts consecutive cycles with any stall bit set and
// raises a sticky error once the run length reaches MAX_STALL.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stall_active  current cycle has a non-zero stall vector
//   hang_err      sticky error, cleared only by rst
module spu_stall_watchdog #(
    parameter int MAX_STALL = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_active,
    output logic hang_err
);

    localparam logic [10:0] LIMIT = 11'(MAX_STALL);

    logic [9:0]  stall_cnt;
    logic [10:0] cnt_inc;

    // One bit wider so the compare is correct even at the saturation point.
    assign cnt_inc = {1'b0, stall_cnt} + 11'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            hang_err  <= 1'b0;
        end else begin
            if (!stall_active) begin
                stall_cnt <= '0;
            end else if (stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 10'd1;
            end
            // This cycle is stall number cnt_inc; flag becomes visible next cycle.
            if (stall_active && (cnt_inc >= LIMIT)) begin
                hang_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/spu_pipe_ctrl.sv
// Central stall/flush sequencer for the dual-issue SPU pipeline.
// Merges per-stage stall requests and multi-cycle EX occupancy into one
// stall vector, turns a taken FF-stage branch into a timed flush plus PC
// redirect, and runs a stall watchdog.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       spu_pipe_ctrl_if.slave: stall requests, multi-cycle start and
//             latency, branch flag/target in; stall, flush, pc_redirect,
//             new_pc, mc_done, mc_abort, hang_err, dbg_state out
module spu_pipe_ctrl
    import spu_pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int MAX_STALL    = 255
) (
    input  logic               clk,
    input  logic               rst,
    spu_pipe_ctrl_if.slave     bus
);

    pipe_state_e           state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic [2:0]            fl_cnt, fl_next;
    logic [0:STALL_BUS6-1] stall_o;
    logic [0:STALL_BUS6-1] req;
    logic                  mc_done_o;
    logic                  take_br;
    logic                  abort_now;
    logic                  mc_go;
    logic [3:0]            lat;
    logic                  pc_redirect_q;
    logic                  mc_abort_q;
    logic [0:31]           new_pc_q;

    assign lat   = bus.ex_mc_lat;
    assign req   = req_mask(bus.if_stall_req, bus.id_stall_req,
                            bus.ex_stall_req, bus.ff_stall_req);
    // A zero-latency start is not an operation at all.
    assign mc_go = bus.ex_mc_start && (lat != 4'd0);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fl_next    = fl_cnt;
        stall_o    = STALL_NONE;
        mc_done_o  = 1'b0;
        take_br    = 1'b0;
        abort_now  = 1'b0;
        // Outputs stay quiet while reset is held so a reset landing on the
        // last MC_WAIT cycle cannot emit a stray mc_done.
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (bus.ff_branch_flag) begin
                        take_br    = 1'b1;
                        abort_now  = mc_go;
                        cnt_next   = 4'd0;
                        fl_next    = 3'(FLUSH_CYCLES - 1);
                        state_next = ST_FLUSH;
                    end else if (mc_go) begin
                        // Start cycle counts as the first of N stall cycles.
                        stall_o = req | STALL_EX;
                        if (lat == 4'd1) begin
                            mc_done_o = 1'b1;
                        end else begin
                            cnt_next   = lat - 4'd1;
                            state_next = ST_MC_WAIT;
                        end
                    end else begin
                        stall_o = req;
                    end
                end
                ST_MC_WAIT: begin
                    if (bus.ff_branch_flag) begin
                        take_br    = 1'b1;
                        abort_now  = 1'b1;
                        cnt_next   = 4'd0;
                        fl_next    = 3'(FLUSH_CYCLES - 1);
                        state_next = ST_FLUSH;
                    end else begin
                        // ID/EX is frozen, so lower requests and new starts are moot.
                        stall_o = bus.ff_stall_req ? STALL_FF : STALL_EX;
                        if (cnt == 4'd1) begin
                            mc_done_o  = 1'b1;
                            cnt_next   = 4'd0;
                            state_next = ST_RUN;
                        end else begin
                            cnt_next = cnt - 4'd1;
                        end
                    end
                end
                ST_FLUSH: begin
                    // Everything arriving now belongs to squashed instructions.
                    if (fl_cnt == 3'd0) begin
                        state_next = ST_RUN;
                    end else begin
                        fl_next = fl_cnt - 3'd1;
                    end
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_RUN;
            cnt           <= 4'd0;
            fl_cnt        <= 3'd0;
            pc_redirect_q <= 1'b0;
            mc_abort_q    <= 1'b0;
            new_pc_q      <= '0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            fl_cnt        <= fl_next;
            pc_redirect_q <= take_br;
            mc_abort_q    <= abort_now;
            if (take_br) begin
                new_pc_q <= bus.ff_branch_target_addr;
            end
        end
    end

    spu_stall_watchdog #(
        .MAX_STALL (MAX_STALL)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_active (|stall_o),
        .hang_err     (bus.hang_err)
    );

    assign bus.stall       = stall_o;
    assign bus.flush       = (state == ST_FLUSH);
    assign bus.pc_redirect = pc_redirect_q;
    assign bus.new_pc      = new_pc_q;
    assign bus.mc_done     = mc_done_o;
    assign bus.mc_abort    = mc_abort_q;
    assign bus.dbg_state   = state;

endmodule

// File: doc/spu_pipe_ctrl.md
Name: spu_pipe_ctrl

Overview:
- Central stall/flush sequencer for the dual-issue SPU pipeline (PC, IF/ID, ID/EX, EX/FF, FF/WB, WB stage registers).
- Merges per-stage stall requests and multi-cycle EX-unit occupancy into one stall vector.
- Turns a resolved FF-stage branch into a timed flush plus PC redirect.
- Runs a stall watchdog. Sits beside the stage registers, which consume stall/flush.

Parameters:
- FLUSH_CYCLES, 1, cycles flush stays asserted after a taken branch (1..7).
- MAX_STALL, 255, continuous stall cycles before hang_err sets (1..1023).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_stall_req  in  1  IF stage needs to hold.
- id_stall_req  in  1  ID stage hazard hold.
- ex_stall_req  in  1  EX single-cycle hold.
- ff_stall_req  in  1  FF stage hold.
- ex_mc_start  in  1  pulse: multi-cycle EX op begins.
- ex_mc_lat  in  [0:3]  total occupancy N of that op, in cycles.
- ff_branch_flag  in  1  taken branch resolved in FF.
- ff_branch_target_addr  in  [0:31]  redirect target.
- stall  out  [0:5]  freeze bits; bit0=PC, 1=IF/ID, 2=ID/EX, 3=EX/FF, 4=FF/WB, 5=WB.
- flush  out  1  clear IF/ID..FF/WB contents.
- pc_redirect  out  1  load new_pc into PC, one-cycle pulse.
- new_pc  out  [0:31]  redirect address.
- mc_done  out  1  last stall cycle of a multi-cycle op.
- mc_abort  out  1  multi-cycle op killed by branch.
- hang_err  out  1  sticky watchdog error.

Behaviour:
- Reset: all outputs 0, state RUN, counters 0. Reset mid-MC_WAIT or mid-FLUSH aborts with no mc_done or mc_abort.
- Stall masks are combinational from state and current requests. The highest-numbered requester wins; its mask is a superset of the lower ones.
  - if 110000
  - id 111000
  - ex or MC 111100
  - ff 111110
  - none 000000
  - Bit 5 is never set by this block.
- States: RUN, MC_WAIT, FLUSH.
- RUN:
  - Outputs the stall mask.
  - ex_mc_start with N≥2: stall EX mask this cycle, load cnt=N-1, go to MC_WAIT.
  - N=1: one stall cycle, mc_done=1 this cycle, stay RUN.
  - N=0: start ignored.
- MC_WAIT:
  - stall ≥ EX mask, ORed with ff_stall_req giving the FF mask. Requests from lower stages are subsumed.
  - cnt decrements each cycle. mc_done=1 when cnt==1, then return to RUN.
  - Total stall cycles = N exactly, including the start cycle.
  - ex_mc_start while in MC_WAIT is ignored, because ID/EX is frozen.
- Branch, any state except FLUSH:
  - ff_branch_flag=1 in cycle t overrides all stall requests in cycle t; stall forced to 000000.
  - Registered effects: flush=1 from cycle t+1 for FLUSH_CYCLES cycles. pc_redirect=1 and new_pc=target latched in cycle t+1 only; new_pc holds afterwards.
  - State goes to FLUSH.
  - If the branch arrives in MC_WAIT, or coincides with an ex_mc_start: the multi-cycle op is killed, mc_abort=1 in t+1, mc_done is never raised, and cnt is cleared.
- FLUSH:
  - stall=000000.
  - All stall requests, ex_mc_start and ff_branch_flag are ignored; they come from instructions being flushed.
  - Returns to RUN after FLUSH_CYCLES cycles. Requests are evaluated normally in the first RUN cycle.
- Watchdog:
  - stall_cnt (10 bits) increments on each cycle with stall≠0 and clears on any cycle with stall=0.
  - hang_err sets when stall_cnt reaches MAX_STALL. It clears only on rst.
  - stall_cnt saturates at its maximum value and never wraps.

Decomposition:
- defines.v gets the following, so stage registers share the encoding:
  - stall mask constants STALL_NONE/IF/ID/EX/FF
  - stage bit indices
  - state encodings RUN/MC_WAIT/FLUSH
  - STALL_BUS6 width macro
- One sub-module, spu_stall_watchdog: counter, saturation and sticky flag. Everything else stays flat.

Test Plan:
- id_stall_req=1 for 3 cycles, others 0 -> stall=111000 for exactly those 3 cycles, then 000000; flush stays 0.
- ex_mc_start with ex_mc_lat=4, id_stall_req=1 during it -> stall=111100 for 4 cycles, mc_done only on the 4th; ex_mc_lat=1 -> one cycle, mc_done the same cycle; ex_mc_lat=0 -> no stall.
- ff_branch_flag=1 with target 0x0000_1A40 while ff_stall_req=1 -> stall=000000 that cycle; next cycle flush=1, pc_redirect=1, new_pc=0x0000_1A40; with FLUSH_CYCLES=3, flush lasts 3 cycles; a second branch inside the window is ignored.
- Start a lat=8 op, branch on its 3rd cycle -> mc_abort=1 the next cycle, mc_done never asserted, state returns to RUN after the flush.
- MAX_STALL=5, ff_stall_req held 10 cycles -> hang_err rises after the 5th stall cycle and stays 1 after the request drops; rst clears it.
- Assert rst during MC_WAIT and during FLUSH -> all outputs 0 the next cycle, no done/abort pulse, normal operation afterwards.
